// File: rtl/wb_stage.sv
// Buffered writeback stage: selects the writeback value, queues results in a small FIFO,
// and drains the head into the register-file write port; the head doubles as a bypass source.
module wb_stage #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned REG_ADDR_W = 3,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              wb_op,
    input  logic [WIDTH-1:0]        alu_out,
    input  logic [WIDTH-1:0]        mem_out,
    input  logic [WIDTH-1:0]        next_pc_basic,
    input  logic                    flag,
    input  logic [REG_ADDR_W-1:0]   rd,
    input  logic                    rd_we,
    output logic                    rf_we,
    input  logic                    rf_ready,
    output logic [REG_ADDR_W-1:0]   rf_waddr,
    output logic [WIDTH-1:0]        rf_wdata,
    output logic                    byp_valid,
    output logic [REG_ADDR_W-1:0]   byp_addr,
    output logic [WIDTH-1:0]        byp_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        OP_ALU     = 3'b000,
        OP_MEM     = 3'b001,
        OP_FLAG    = 3'b010,
        OP_LINK    = 3'b011,
        OP_MEM_BSX = 3'b100,
        OP_MEM_BZX = 3'b101
    } wb_op_e;

    logic [REG_ADDR_W-1:0] addr_q [DEPTH];
    logic [REG_ADDR_W-1:0] addr_d [DEPTH];
    logic                  we_q   [DEPTH];
    logic                  we_d   [DEPTH];
    logic [WIDTH-1:0]      data_q [DEPTH];
    logic [WIDTH-1:0]      data_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  err_q, err_d;

    logic [WIDTH-1:0]      sel_data;
    logic                  illegal;
    logic                  head_valid;
    logic                  push;
    logic                  pop;

    always_comb begin
        sel_data = '0;
        illegal  = 1'b0;
        case (wb_op_e'(wb_op))
            OP_ALU:     sel_data = alu_out;
            OP_MEM:     sel_data = mem_out;
            OP_FLAG:    sel_data = {{(WIDTH-1){1'b0}}, flag};
            OP_LINK:    sel_data = next_pc_basic;
            OP_MEM_BSX: sel_data = {{(WIDTH-8){mem_out[7]}}, mem_out[7:0]};
            OP_MEM_BZX: sel_data = {{(WIDTH-8){1'b0}}, mem_out[7:0]};
            default:    illegal  = 1'b1;
        endcase
    end

    assign head_valid = (count_q != '0);
    assign in_ready   = (count_q != CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    // Non-writing entries retire without waiting on the register file.
    assign pop        = head_valid && (!we_q[rd_ptr_q] || rf_ready);

    always_comb begin
        addr_d   = addr_q;
        we_d     = we_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        err_d    = err_q;
        if (push) begin
            addr_d[wr_ptr_q] = rd;
            we_d[wr_ptr_q]   = rd_we && !illegal;
            data_d[wr_ptr_q] = sel_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            err_d            = err_q || illegal;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                we_q[i]   <= 1'b0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            we_q     <= we_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign rf_we     = head_valid && we_q[rd_ptr_q];
    assign rf_waddr  = addr_q[rd_ptr_q];
    assign rf_wdata  = data_q[rd_ptr_q];
    assign byp_valid = rf_we;
    assign byp_addr  = addr_q[rd_ptr_q];
    assign byp_data  = data_q[rd_ptr_q];
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised, buffered writeback stage for the unpipelined/pipelined processor datapath. It selects the writeback value from the ALU result, memory data, flag or link address, with new sign- and zero-extended byte-load modes. It queues completed results in a DEPTH-entry FIFO and drains them into the register-file write port under a valid/ready handshake. The queue head is exposed as a bypass source for forwarding.

## Interface
- WIDTH, 16: datapath width; minimum 9.
- REG_ADDR_W, 3: register address width.
- DEPTH, 2: queue entries; power of two, at least 2.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  result presented.
- in_ready  out  1  stage can accept; depends only on registered state.
- wb_op  in  3  000 ALU, 001 MEM, 010 FLAG, 011 LINK, 100 MEM_BSX, 101 MEM_BZX, 11x illegal.
- alu_out, mem_out, next_pc_basic  in  WIDTH each  candidate sources.
- flag  in  1  condition result.
- rd  in  REG_ADDR_W  destination register.
- rd_we  in  1  result writes the register file.
- rf_we  out  1  write request from queue head.
- rf_ready  in  1  register file accepts the write this cycle.
- rf_waddr  out  REG_ADDR_W  head destination.
- rf_wdata  out  WIDTH  head data.
- byp_valid  out  1  head holds a pending register write.
- byp_addr  out  REG_ADDR_W  head destination for forwarding.
- byp_data  out  WIDTH  head data for forwarding.
- count  out  clog2(DEPTH)+1  occupancy.
- err  out  1  sticky illegal-op flag.

## Operation
- Select rules, computed combinationally from the inputs:
  - ALU: alu_out.
  - MEM: mem_out.
  - FLAG: {WIDTH-1 zeros, flag}.
  - LINK: next_pc_basic.
  - MEM_BSX: mem_out[7:0], sign-extended from bit 7 to WIDTH.
  - MEM_BZX: mem_out[7:0], zero-extended to WIDTH.
  - Illegal: data 0.
- Push when in_valid && in_ready. The entry stores {rd, rd_we, data}.
  - Illegal op: the entry is pushed with we forced to 0, and err is set.
  - err holds until reset.
- Head signals:
  - rf_we = head_valid && head.we.
  - rf_waddr and rf_wdata always drive the head fields.
- Pop condition: head_valid && (!head.we || rf_ready).
  - Non-writing entries retire in one cycle without waiting on rf_ready.
- Bypass outputs: byp_valid = rf_we, with byp_addr and byp_data equal to the head fields.
  - Entries behind the head are not exposed on the bypass.
- in_ready = (count != DEPTH).
  - When full, a pop in the same cycle does not enable a push; there is no combinational path from rf_ready to in_ready.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
- FIFO order is strict; entries never reorder.

## Timing
- Reset (rst low, asynchronous): count=0, pointers=0, err=0, all storage=0.
  - Resulting outputs: rf_we=0, byp_valid=0, rf_waddr=0, rf_wdata=0, in_ready=1.
- Reset mid-operation discards all queued entries; no write issues after reset asserts.
- Latency: an entry accepted at edge N appears on rf_we after edge N. It writes at edge N+1 if rf_ready=1.
  - Minimum latency is 1 cycle; there is no flow-through.
- Throughput: 1 entry per cycle when rf_ready is held high.
- With rf_ready low and a writing head: the queue fills in DEPTH cycles, then in_ready drops.
  - in_ready rises the cycle after the first pop.
- Empty with in_valid: nothing appears on the rf_* outputs in the same cycle.

## Test plan
- Reset, then push ALU op (alu_out=16'h1234, rd=5, rd_we=1) with rf_ready=1.
  - Next cycle: rf_we=1, rf_waddr=5, rf_wdata=16'h1234, byp_valid=1.
  - The following cycle: count=0.
- Push MEM_BSX and MEM_BZX with mem_out=16'hAB80.
  - Written data is 16'hFF80, then 16'h0080, in order.
- Hold rf_ready=0 and push 3 writing entries (DEPTH=2).
  - Third entry waits because in_ready=0 after 2 accepts.
  - Raise rf_ready: writes drain in order, and in_ready returns 1 cycle after the first pop.
- Push wb_op=3'b110 with rd_we=1.
  - err=1, and the entry retires without rf_we.
  - Following FLAG op (flag=1) writes 16'h0001; err stays 1.
- Continuous push/pop for 10 cycles with rf_ready=1.
  - count stays 1, pointers wrap, all 10 values are written in order.
- Assert rst low with 2 entries queued.
  - Immediately: rf_we=0, count=0, err=0, in_ready=1.
